// File: rtl/hazard_pkg.sv
// Shared constants for the hazard scoreboard: register and timing field widths,
// pipeline stage indices, and the encoding for a source that is not read.
package hazard_pkg;

    localparam int AW = 5;    // register address width
    localparam int TW = 2;    // Tnew/Tuse field width

    // Stage indices of the tracked post-decode stages.
    localparam int STG_E = 1;
    localparam int STG_M = 2;
    localparam int STG_W = 3;

    // A Tuse of all ones marks the source as unused.
    localparam logic [TW-1:0] TUSE_NONE = '1;

endpackage : hazard_pkg

// File: rtl/md_busy_timer.sv
// Multiply/divide unit occupancy timer. A start loads the operation latency;
// the count then drains by one per cycle. Busy covers the starting cycle too.
module md_busy_timer #(
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int MAXC = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          start_q;

    // Next count: reload on a start, otherwise count down towards zero.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = is_div ? CW'(DIV_CYC) : CW'(MUL_CYC);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Countdown and start-in-E flag; reset abandons any in-flight operation.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            cnt_q   <= '0;
            start_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            start_q <= start;
        end
    end

    assign busy = (cnt_q != '0) || start_q;

endmodule : md_busy_timer

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks destination registers in E/M/W with
// their remaining Tnew, resolves each D-stage source against the youngest
// producer, and raises stall / forwarding selects plus an MDU busy interlock.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NSTAGE  = 3,
    parameter int AW      = hazard_pkg::AW,
    parameter int TW      = hazard_pkg::TW,
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          id_valid,
    input  logic [AW-1:0]                 id_rs,
    input  logic [AW-1:0]                 id_rt,
    input  logic [TW-1:0]                 id_tuse_rs,
    input  logic [TW-1:0]                 id_tuse_rt,
    input  logic [AW-1:0]                 id_wr_addr,
    input  logic [TW-1:0]                 id_tnew,
    input  logic                          id_md_start,
    input  logic                          id_md_div,
    input  logic                          id_md_use,
    output logic                          stall,
    output logic [$clog2(NSTAGE+1)-1:0]   fwd_sel_rs,
    output logic [$clog2(NSTAGE+1)-1:0]   fwd_sel_rt,
    output logic                          md_busy,
    output logic [31:0]                   stall_cnt
);

    localparam int SW = $clog2(NSTAGE + 1);

    logic          valid_q [STG_E:NSTAGE];
    logic          valid_d [STG_E:NSTAGE];
    logic [AW-1:0] addr_q  [STG_E:NSTAGE];
    logic [AW-1:0] addr_d  [STG_E:NSTAGE];
    logic [TW-1:0] tnew_q  [STG_E:NSTAGE];
    logic [TW-1:0] tnew_d  [STG_E:NSTAGE];
    logic [31:0]   stall_cnt_q;

    logic rs_used, rt_used;
    logic hz_rs, hz_rt, md_stall, md_start_e;

    // All-ones Tuse (TUSE_NONE) means the source is not read.
    assign rs_used = ~&id_tuse_rs;
    assign rt_used = ~&id_tuse_rt;

    // Source resolution: scan oldest to youngest so the youngest match wins.
    always_comb begin
        hz_rs      = 1'b0;
        hz_rt      = 1'b0;
        fwd_sel_rs = '0;
        fwd_sel_rt = '0;
        for (int k = NSTAGE; k >= STG_E; k--) begin
            if (valid_q[k] && (addr_q[k] != '0)) begin
                if (rs_used && (addr_q[k] == id_rs)) begin
                    hz_rs      = (tnew_q[k] > id_tuse_rs);
                    fwd_sel_rs = (tnew_q[k] == '0) ? SW'(k) : '0;
                end
                if (rt_used && (addr_q[k] == id_rt)) begin
                    hz_rt      = (tnew_q[k] > id_tuse_rt);
                    fwd_sel_rt = (tnew_q[k] == '0) ? SW'(k) : '0;
                end
            end
        end
    end

    assign md_stall   = id_md_use && md_busy;
    assign stall      = id_valid && (hz_rs || hz_rt || md_stall);
    assign md_start_e = id_valid && id_md_start && !stall;

    // Pipeline shift: D (or a bubble) enters E, older entries age by one stage.
    always_comb begin
        valid_d[STG_E] = id_valid && !stall;
        addr_d[STG_E]  = id_wr_addr;
        tnew_d[STG_E]  = id_tnew;
        for (int k = STG_E + 1; k <= NSTAGE; k++) begin
            valid_d[k] = valid_q[k-1];
            addr_d[k]  = addr_q[k-1];
            tnew_d[k]  = (tnew_q[k-1] != '0) ? tnew_q[k-1] - 1'b1 : '0;
        end
    end

    // Entry valid bits, cleared on reset.
    always_ff @(posedge clk) begin
        for (int k = STG_E; k <= NSTAGE; k++) begin
            if (reset) valid_q[k] <= 1'b0;
            else       valid_q[k] <= valid_d[k];
        end
    end

    // Entry payload; meaningless while the entry is invalid.
    always_ff @(posedge clk) begin
        // NOTE: payload arrays carry no reset -- the valid bits alone qualify them.
        for (int k = STG_E; k <= NSTAGE; k++) begin
            addr_q[k] <= addr_d[k];
            tnew_q[k] <= tnew_d[k];
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (reset)                                   stall_cnt_q <= '0;
        else if (stall && (stall_cnt_q != '1))       stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;

    md_busy_timer #(
        .MUL_CYC (MUL_CYC),
        .DIV_CYC (DIV_CYC)
    ) u_md_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start_e),
        .is_div (id_md_div),
        .busy   (md_busy)
    );

endmodule : hazard_scoreboard

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios followed by
// random instruction streams, compared against a cycle-history reference model.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int MULC = 5;
    localparam int DIVC = 10;
    localparam int HMAX = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_wr_addr;
    logic [1:0]  id_tuse_rs, id_tuse_rt, id_tnew;
    logic        id_md_start, id_md_div, id_md_use;
    logic        stall, md_busy;
    logic [1:0]  fwd_sel_rs, fwd_sel_rt;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NSTAGE (3), .AW (5), .TW (2), .MUL_CYC (MULC), .DIV_CYC (DIVC)
    ) dut (
        .clk (clk), .reset (reset), .id_valid (id_valid),
        .id_rs (id_rs), .id_rt (id_rt),
        .id_tuse_rs (id_tuse_rs), .id_tuse_rt (id_tuse_rt),
        .id_wr_addr (id_wr_addr), .id_tnew (id_tnew),
        .id_md_start (id_md_start), .id_md_div (id_md_div), .id_md_use (id_md_use),
        .stall (stall), .fwd_sel_rs (fwd_sel_rs), .fwd_sel_rt (fwd_sel_rt),
        .md_busy (md_busy), .stall_cnt (stall_cnt)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [1:0] trs;
        logic [4:0] rt;
        logic [1:0] trt;
        logic [4:0] wr;
        logic [1:0] tn;
        logic       ms;
        logic       md;
        logic       mu;
    } ins_t;

    // Reference model: which instruction entered E on each cycle.
    bit          h_valid [0:HMAX-1];
    int          h_addr  [0:HMAX-1];
    int          h_tnew  [0:HMAX-1];
    int          cyc, base, md_end;
    logic [31:0] m_cnt;

    int          n_assert, n_fail;
    logic        s_stall, s_busy;
    logic [1:0]  s_rs, s_rt;
    logic [31:0] s_cnt;

    function automatic ins_t op(input bit v, input int rs, input int trs, input int rt,
                                input int trt, input int wr, input int tn,
                                input bit ms, input bit md, input bit mu);
        ins_t r;
        r.v = v; r.rs = 5'(rs); r.trs = 2'(trs); r.rt = 5'(rt); r.trt = 2'(trt);
        r.wr = 5'(wr); r.tn = 2'(tn); r.ms = ms; r.md = md; r.mu = mu;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Youngest in-flight producer of src decides; its remaining Tnew is its
    // Tnew minus the number of stages it has already moved past E.
    task automatic model_src(input int src, input int tuse, output bit hz, output int sel);
        hz = 0;
        sel = 0;
        if (tuse == int'(TUSE_NONE) || src == 0) return;
        for (int k = 1; k <= 3; k++) begin
            int idx;
            int rem;
            idx = cyc - k + 1;
            if (idx >= base && h_valid[idx] && h_addr[idx] == src) begin
                rem = h_tnew[idx] - (k - 1);
                if (rem < 0) rem = 0;
                hz  = rem > tuse;
                sel = (rem == 0) ? k : 0;
                return;
            end
        end
    endtask

    // One clock cycle: drive D, check outputs at the falling edge, advance the model.
    task automatic cycle(input ins_t in, input bit rst);
        bit hzs, hzt, mbusy, e_stall;
        int sel_s, sel_t;
        id_valid = in.v; id_rs = in.rs; id_rt = in.rt;
        id_tuse_rs = in.trs; id_tuse_rt = in.trt;
        id_wr_addr = in.wr; id_tnew = in.tn;
        id_md_start = in.ms; id_md_div = in.md; id_md_use = in.mu;
        reset = rst;
        @(negedge clk);
        model_src(int'(in.rs), int'(in.trs), hzs, sel_s);
        model_src(int'(in.rt), int'(in.trt), hzt, sel_t);
        mbusy   = cyc < md_end;
        e_stall = in.v && (hzs || hzt || (in.mu && mbusy));
        s_stall = stall; s_rs = fwd_sel_rs; s_rt = fwd_sel_rt;
        s_busy = md_busy; s_cnt = stall_cnt;
        if (!rst) begin
            chk("stall", {31'd0, stall}, {31'd0, e_stall});
            chk("fwd_sel_rs", {30'd0, fwd_sel_rs}, 32'(sel_s));
            chk("fwd_sel_rt", {30'd0, fwd_sel_rt}, 32'(sel_t));
            chk("md_busy", {31'd0, md_busy}, {31'd0, mbusy});
            chk("stall_cnt", stall_cnt, m_cnt);
        end
        @(posedge clk);
        if (rst) begin
            base = cyc + 1;
            h_valid[cyc+1] = 0;
            md_end = 0;
            m_cnt = 0;
        end else begin
            h_valid[cyc+1] = in.v && !e_stall;
            h_addr[cyc+1]  = int'(in.wr);
            h_tnew[cyc+1]  = int'(in.tn);
            if (in.v && in.ms && !e_stall) md_end = cyc + 1 + (in.md ? DIVC : MULC);
            if (e_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
        cyc++;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ins_t bub, mfhi, ins;
        int n;
        n_assert = 0; n_fail = 0;
        cyc = 0; base = 0; md_end = 0; m_cnt = 0;
        bub  = op(0, 0, 3, 0, 3, 0, 0, 0, 0, 0);
        mfhi = op(1, 0, 3, 0, 3, 8, 1, 0, 0, 1);
        id_valid = 0; id_rs = 0; id_rt = 0; id_tuse_rs = 3; id_tuse_rt = 3;
        id_wr_addr = 0; id_tnew = 0; id_md_start = 0; id_md_div = 0; id_md_use = 0;
        reset = 1;
        @(posedge clk); #1;

        cycle(bub, 1);
        cycle(bub, 1);
        cycle(bub, 0);
        chk("reset_stall", {31'd0, s_stall}, 32'd0);
        chk("reset_fwd_rs", {30'd0, s_rs}, 32'd0);
        chk("reset_md_busy", {31'd0, s_busy}, 32'd0);
        chk("reset_stall_cnt", s_cnt, 32'd0);

        // jal $31 then beq on $31: forward from E.
        cycle(op(1, 0, 3, 0, 3, 31, 0, 0, 0, 0), 0);
        cycle(op(1, 31, 0, 0, 3, 0, 0, 0, 0, 0), 0);
        chk("jal_beq_stall", {31'd0, s_stall}, 32'd0);
        chk("jal_beq_fwd", {30'd0, s_rs}, 32'd1);

        // addu $3 then beq on $3: one stall, then forward from M.
        cycle(op(1, 0, 3, 0, 3, 3, 1, 0, 0, 0), 0);
        cycle(op(1, 3, 0, 0, 3, 0, 0, 0, 0, 0), 0);
        chk("addu_beq_stall", {31'd0, s_stall}, 32'd1);
        cycle(op(1, 3, 0, 0, 3, 0, 0, 0, 0, 0), 0);
        chk("addu_beq_go", {31'd0, s_stall}, 32'd0);
        chk("addu_beq_fwd", {30'd0, s_rs}, 32'd2);

        // lw $1 then addu reading $1 at Tuse 1: one stall, then no D-stage forward.
        cycle(op(1, 0, 3, 0, 3, 1, 2, 0, 0, 0), 0);
        cycle(op(1, 1, 1, 0, 3, 4, 1, 0, 0, 0), 0);
        chk("lw_use_stall", {31'd0, s_stall}, 32'd1);
        cycle(op(1, 1, 1, 0, 3, 4, 1, 0, 0, 0), 0);
        chk("lw_use_go", {31'd0, s_stall}, 32'd0);
        chk("lw_use_fwd", {30'd0, s_rs}, 32'd0);

        // Register 0 never creates a dependency.
        cycle(op(1, 0, 3, 0, 3, 0, 2, 0, 0, 0), 0);
        cycle(op(1, 0, 0, 0, 0, 5, 1, 0, 0, 0), 0);
        chk("r0_stall", {31'd0, s_stall}, 32'd0);
        chk("r0_fwd_rs", {30'd0, s_rs}, 32'd0);
        chk("r0_fwd_rt", {30'd0, s_rt}, 32'd0);

        // mult then mfhi: mfhi waits out the multiply latency.
        cycle(op(1, 0, 3, 0, 3, 0, 0, 1, 0, 1), 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(mfhi, 0);
            if (!s_stall) break;
            n++;
        end
        chk("mul_stall_cycles", 32'(n), 32'd5);
        chk("mul_busy_done", {31'd0, s_busy}, 32'd0);

        // div then mfhi, with the stall counter preloaded near saturation.
        cycle(op(1, 0, 3, 0, 3, 0, 0, 1, 1, 1), 0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(mfhi, 0);
            if (!s_stall) break;
            n++;
            if (n == 2) begin
                force dut.stall_cnt_q = 32'hFFFF_FFFA;
                #1;
                release dut.stall_cnt_q;
                m_cnt = 32'hFFFF_FFFA;
            end
        end
        chk("div_stall_cycles", 32'(n), 32'd10);
        chk("stall_cnt_saturated", s_cnt, 32'hFFFF_FFFF);

        // Reset during an in-flight multiply abandons it.
        cycle(op(1, 0, 3, 0, 3, 0, 0, 1, 0, 1), 0);
        cycle(mfhi, 0);
        cycle(mfhi, 0);
        cycle(mfhi, 1);
        cycle(bub, 0);
        chk("rst_mdu_busy", {31'd0, s_busy}, 32'd0);
        chk("rst_mdu_cnt", s_cnt, 32'd0);

        // Random instruction mix over a small register set to provoke hazards.
        for (int i = 0; i < 800; i++) begin
            ins.v  = ($urandom_range(0, 9) < 8);
            ins.rs = 5'($urandom_range(0, 3));
            ins.rt = 5'($urandom_range(0, 3));
            ins.trs = 2'($urandom_range(0, 3));
            ins.trt = 2'($urandom_range(0, 3));
            ins.wr = 5'($urandom_range(0, 3));
            ins.tn = 2'($urandom_range(0, 3));
            ins.ms = ($urandom_range(0, 19) == 0);
            ins.md = 1'($urandom_range(0, 1));
            ins.mu = ins.ms || ($urandom_range(0, 9) == 0);
            cycle(ins, ($urandom_range(0, 99) == 0));
        end
        cycle(bub, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_hazard_scoreboard

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL: parameter NSTAGE, 3, number of tracked post-decode stages (1=E, 2=M, 3=W).
REQ-002 SHALL: parameter AW, 5, register address width.
REQ-003 SHALL: parameter TW, 2, Tnew/Tuse field width.
REQ-004 SHALL: parameter MUL_CYC, 5, multiply busy cycles.
REQ-005 SHALL: parameter DIV_CYC, 10, divide busy cycles.
REQ-006 SHALL: clk  in  1  sole clock, rising edge.
REQ-007 SHALL: reset  in  1  synchronous, active-high.
REQ-008 SHALL: id_valid  in  1  D-stage holds a real instruction.
REQ-009 SHALL: id_rs, id_rt  in  AW  D-stage source registers.
REQ-010 SHALL: id_tuse_rs, id_tuse_rt  in  TW  cycles until each source is consumed; all-ones means the source is unused.
REQ-011 SHALL: id_wr_addr  in  AW  destination; 0 means no write.
REQ-012 SHALL: id_tnew  in  TW  cycles after entering E until the result can be forwarded.
REQ-013 SHALL: id_md_start, id_md_div  in  1  D-stage instruction starts MDU; 1=divide, 0=multiply.
REQ-014 SHALL: id_md_use  in  1  D-stage instruction reads or writes HI/LO or starts MDU.
REQ-015 SHALL: stall  out  1  hold PC/D, insert bubble into E.
REQ-016 SHALL: fwd_sel_rs, fwd_sel_rt  out  $clog2(NSTAGE+1)  D-stage source select; 0=register file, k=stage k.
REQ-017 SHALL: md_busy  out  1  MDU occupied.
REQ-018 SHALL: stall_cnt  out  32  saturating count of stall cycles.

Function
REQ-019 SHALL: keep NSTAGE entries {valid, addr, tnew}; entry 1 is E.
REQ-020 SHALL: every cycle shift entry k to k+1; the W entry is discarded; tnew of shifted entries becomes max(tnew-1,0).
REQ-021 SHALL: load entry 1 from D when id_valid=1 and stall=0; otherwise load a bubble (valid=0).
REQ-022 SHALL: a source matches entry k when the entry is valid, the source is used, addr==source and addr!=0; register 0 never matches.
REQ-023 SHALL: decide each source using only the youngest matching entry (lowest k).
REQ-024 SHALL: assert stall combinationally when the youngest match has tnew > source tuse.
REQ-025 SHALL: set fwd_sel to k when the youngest match has tnew==0; otherwise set fwd_sel to 0. A nonzero tnew within tuse is resolved by later-stage forwarding.
REQ-026 SHALL: hold an MDU countdown; load MUL_CYC or DIV_CYC when a non-stalled id_md_start enters E; decrement to 0 each cycle.
REQ-027 SHALL: drive md_busy=1 while the countdown is nonzero or an md_start is in entry 1.
REQ-028 SHALL: assert stall when id_valid=1, id_md_use=1 and md_busy=1.
REQ-029 SHALL: OR the register-hazard and MDU stall causes; force stall=0 when id_valid=0.
REQ-030 SHALL: increment stall_cnt on each cycle with stall=1, saturating at 0xFFFFFFFF.

Reset
REQ-031 SHALL: on reset, clear all entries to invalid, the countdown to 0 and stall_cnt to 0; outputs are then stall=0, fwd_sel=0 and md_busy=0.
REQ-032 SHALL: abandon any in-flight MDU operation on reset; reset has priority over a simultaneous load.

Structure
REQ-033 SHALL: place AW, TW, the stage-index constants and the TUSE_NONE encoding in shared package hazard_pkg.
REQ-034 SHALL: implement the MDU countdown as sub-module md_busy_timer (inputs start, is_div; output busy).

Verification
REQ-035 SHALL: jal ($31, tnew=0) in E, then beq on $31 (tuse=0) -> stall=0, fwd_sel_rs=1.
REQ-036 SHALL: addu $3 (tnew=1), then beq on $3 (tuse=0) -> one stall cycle, then fwd_sel_rs=2 with stall=0.
REQ-037 SHALL: lw $1 (tnew=2), then addu reading $1 (tuse=1) -> one stall, then stall=0 with fwd_sel_rs=0.
REQ-038 SHALL: write $0 with tnew=2, then read $0 with tuse=0 -> stall=0, fwd_sel=0.
REQ-039 SHALL: mult, then mfhi -> stall for 5 cycles, md_busy falls, then mfhi issues; for div the stall lasts 10 cycles; assert reset at cycle 3 -> md_busy=0 next cycle.
REQ-040 SHALL: stall_cnt preloaded near 0xFFFFFFFF with a sustained stall -> holds 0xFFFFFFFF.
